// File: rtl/prim_ram_1p_arb.sv
// prim_ram_1p_arb: zero-fill sequencer and round-robin arbiter in front of a single-port SRAM
module prim_ram_1p_arb #(
   parameter int Width = 32,
   parameter int Depth = 128,
   parameter int NumReq = 2,
   parameter bit InitOnReset = 1'b1,
   localparam int Aw = $clog2(Depth)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NumReq-1:0]        req_i,
   input  logic [NumReq-1:0]        write_i,
   input  logic [NumReq*Aw-1:0]     addr_i,
   input  logic [NumReq*Width-1:0]  wdata_i,
   input  logic [NumReq*Width-1:0]  wmask_i,
   output logic [NumReq-1:0]        gnt_o,
   output logic [NumReq-1:0]        rvalid_o,
   output logic [Width-1:0]         rdata_o,
   input  logic                     init_req_i,
   output logic                     init_done_o,
   output logic                     ram_req_o,
   output logic                     ram_write_o,
   output logic [Aw-1:0]            ram_addr_o,
   output logic [Width-1:0]         ram_wdata_o,
   output logic [Width-1:0]         ram_wmask_o,
   input  logic [Width-1:0]         ram_rdata_i
);
   localparam int Pw = $clog2(NumReq);
   typedef enum logic [1:0] {StRst, StInit, StRun} state_e;
   state_e state_q, state_d;
   logic [Aw-1:0] cnt_q;
   logic [Pw-1:0] ptr_q, ptr_d, win;
   logic [NumReq-1:0] rvalid_q;
   logic init_done_q, any, grant, in_init, last;
   int k;
   // Scan downward from ptr+NumReq-1 so the first requester at or after ptr is the last one kept
   always_comb begin
      win = '0;
      any = 1'b0;
      k = 0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         k = (int'(ptr_q) + i) % NumReq;
         if (req_i[k]) begin
            win = Pw'(k);
            any = 1'b1;
         end
      end
   end
   assign in_init = state_q == StInit;
   assign last    = cnt_q == Aw'(Depth - 1);
   assign grant   = state_q == StRun && any && !init_req_i;
   assign ptr_d   = grant ? Pw'((int'(win) + 1) % NumReq) : ptr_q;
   assign state_d = state_q == StRst ? (InitOnReset ? StInit : StRun) :
                    in_init ? (last ? StRun : StInit) :
                    init_req_i ? StInit : StRun;
   assign gnt_o       = grant ? NumReq'(1) << win : '0;
   assign ram_req_o   = in_init || grant;
   assign ram_write_o = in_init || (grant && write_i[win]);
   assign ram_addr_o  = in_init ? cnt_q : grant ? addr_i[win*Aw +: Aw] : '0;
   assign ram_wdata_o = grant ? wdata_i[win*Width +: Width] : '0;
   assign ram_wmask_o = in_init ? '1 : grant ? wmask_i[win*Width +: Width] : '0;
   assign rdata_o     = ram_rdata_i;
   assign rvalid_o    = rvalid_q;
   assign init_done_o = init_done_q;
   // Sequencer state, sweep counter, round-robin pointer and read-valid pipeline
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StRst;
         cnt_q       <= '0;
         ptr_q       <= '0;
         rvalid_q    <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= in_init && !last ? cnt_q + 1'b1 : '0;
         ptr_q       <= ptr_d;
         rvalid_q    <= grant && !write_i[win] ? gnt_o : '0;
         init_done_q <= state_d == StRun;
      end
   end
   a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
   a_gnt_run:    assert property (@(posedge clk_i) disable iff (!rst_ni) state_q != StRun |-> gnt_o == '0);
   a_gnt_req:    assert property (@(posedge clk_i) disable iff (!rst_ni) (gnt_o & ~req_i) == '0);
   a_req_gnt:    assert property (@(posedge clk_i) disable iff (!rst_ni) state_q == StRun |-> ram_req_o == |gnt_o);
endmodule

// File: tb/tb_prim_ram_1p_arb.sv
// tb_prim_ram_1p_arb: directed bench for the SRAM sweep/arbiter front-end
module tb_prim_ram_1p_arb;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b0, rst0_n = 1'b0, init_req = 1'b0;
   logic [1:0] req = '0, wr = '0;
   logic [1:0][6:0] addr = '0;
   logic [1:0][31:0] wdata = '0, wmask = '0;
   logic [1:0] gnt, rvalid, gnt0, rvalid0;
   logic [31:0] rdata, rdata0, ram_wdata, ram_wmask, ram_wdata0, ram_wmask0, rq;
   logic [31:0] fixed_rdata = 32'h1234_5678;
   logic init_done, ram_req, ram_write, init_done0, ram_req0, ram_write0;
   logic [6:0] ram_addr, ram_addr0;
   logic [31:0] mem [128];
   int errs = 0, checks = 0;

   prim_ram_1p_arb #(.Width(32), .Depth(128), .NumReq(2), .InitOnReset(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
      .wdata_i(wdata), .wmask_i(wmask), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .init_req_i(init_req), .init_done_o(init_done), .ram_req_o(ram_req),
      .ram_write_o(ram_write), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
      .ram_wmask_o(ram_wmask), .ram_rdata_i(rq));

   prim_ram_1p_arb #(.Width(32), .Depth(128), .NumReq(2), .InitOnReset(1'b0)) dut0 (
      .clk_i(clk), .rst_ni(rst0_n), .req_i(req), .write_i(wr), .addr_i(addr),
      .wdata_i(wdata), .wmask_i(wmask), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0),
      .init_req_i(1'b0), .init_done_o(init_done0), .ram_req_o(ram_req0),
      .ram_write_o(ram_write0), .ram_addr_o(ram_addr0), .ram_wdata_o(ram_wdata0),
      .ram_wmask_o(ram_wmask0), .ram_rdata_i(fixed_rdata));

   // RAM model: garbage at start so the sweep is visible, masked writes, 1-cycle read latency
   initial for (int i = 0; i < 128; i++) mem[i] = 32'hA5A5_A5A5;
   always @(posedge clk) begin
      if (ram_req && ram_write) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else if (ram_req) rq <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_done", init_done, 0);
      check("rst_ram", {ram_req, ram_write, ram_addr, ram_wdata, ram_wmask}, 0);
      req = 2'b11;
      addr[0] = 7'd0;
      addr[1] = 7'd127;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         #1;
         check("sweep_req", {ram_req, ram_write}, 2'b11);
         check("sweep_addr", ram_addr, i);
         check("sweep_data", ram_wdata, 0);
         check("sweep_mask", ram_wmask, 32'hFFFF_FFFF);
         check("sweep_gnt", gnt, 0);
         check("sweep_done", init_done, 0);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 4) req = 2'b00;
         #1;
         if (c == 0) check("done_rise", init_done, 1);
         check("alt_gnt", gnt, c == 4 ? 0 : (c % 2 == 1 ? 2'b10 : 2'b01));
         check("alt_rvalid", rvalid, c == 0 ? 0 : (c % 2 == 1 ? 2'b01 : 2'b10));
         if (c > 0) check("alt_rdata", rdata, 0);
      end
      check("idle_req", ram_req, 0);
      @(negedge clk);
      req = 2'b10; wr = 2'b10; addr[1] = 7'd5;
      wdata[1] = 32'hDEAD_BEEF; wmask[1] = 32'hFFFF_0000;
      #1;
      check("wr_gnt", gnt, 2'b10);
      check("wr_port", {ram_req, ram_write, ram_addr}, {2'b11, 7'd5});
      check("wr_data", ram_wdata, 32'hDEAD_BEEF);
      check("wr_mask", ram_wmask, 32'hFFFF_0000);
      @(negedge clk);
      wr = 2'b00;
      #1;
      check("wr_no_rvalid", rvalid, 0);
      check("rd_gnt", gnt, 2'b10);
      @(negedge clk);
      req = 2'b00;
      #1;
      check("rd_rvalid", rvalid, 2'b10);
      check("rd_rdata", rdata, 32'hDEAD_0000);
      @(negedge clk);
      req = 2'b01; addr[0] = 7'd5;
      #1;
      check("pre_init_gnt", gnt, 2'b01);
      @(negedge clk);
      req = 2'b11; init_req = 1'b1;
      #1;
      check("init_req_gnt", gnt, 0);
      check("init_req_ram", ram_req, 0);
      check("init_req_rvalid", rvalid, 2'b01);
      check("init_req_rdata", rdata, 32'hDEAD_0000);
      check("init_req_done", init_done, 1);
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         init_req = 1'b0;
         #1;
         check("reinit_gnt", gnt, 0);
         check("reinit_done", init_done, 0);
         check("reinit_addr", {ram_req, ram_addr}, {1'b1, 7'(i)});
      end
      @(negedge clk);
      req = 2'b10; addr[1] = 7'd5;
      #1;
      check("reinit_rise", init_done, 1);
      check("reinit_rd_gnt", gnt, 2'b10);
      @(negedge clk);
      req = 2'b00;
      #1;
      check("reinit_rvalid", rvalid, 2'b10);
      check("reinit_rdata", rdata, 0);
      @(negedge clk);
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      #1;
      n = 0;
      while (ram_addr != 7'd60 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("reach60", ram_addr, 60);
      rst_n = 1'b0;
      #1;
      check("midrst_ram", {ram_req, ram_write, ram_addr, ram_wdata, ram_wmask}, 0);
      check("midrst_done", {init_done, gnt, rvalid}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("restart0", {ram_req, ram_addr}, {1'b1, 7'd0});
      @(negedge clk);
      #1;
      check("restart1", {ram_req, ram_addr}, {1'b1, 7'd1});
      check("noinit_rst_done", init_done0, 0);
      @(negedge clk);
      rst0_n = 1'b1;
      #1;
      check("noinit_rst_req", ram_req0, 0);
      @(negedge clk);
      #1;
      check("noinit_done", init_done0, 1);
      check("noinit_nowrite", {ram_req0, ram_write0}, 0);
      @(negedge clk);
      req = 2'b01; wr = 2'b00; addr[0] = 7'd3;
      #1;
      check("noinit_gnt", gnt0, 2'b01);
      @(negedge clk);
      req = 2'b00;
      #1;
      check("noinit_rvalid", rvalid0, 2'b01);
      check("noinit_rdata", rdata0, 32'h1234_5678);
      rst0_n = 1'b0;
      #1;
      check("drop_rvalid", rvalid0, 0);
      check("drop_done", init_done0, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/prim_ram_1p_arb.md
# prim_ram_1p_arb

Sequencing front-end for a single-port SRAM (`prim_generic_ram_1p`-style: one access per cycle, read data one cycle after request). Clears the memory with a zero-fill sweep after reset or on demand, then shares the port between `NumReq` requesters using round-robin arbitration. Each requester gets a grant handshake and a registered read-valid strobe. Sits between cache/scratchpad logic and the RAM instance.

## Interface
- `Width`, default 32: data width in bits.
- `Depth`, default 128: number of words; `Aw = $clog2(Depth)` is derived.
- `NumReq`, default 2: number of requesters, legal range 2..8.
- `InitOnReset`, default 1'b1: if set, run the zero-fill sweep after reset; if clear, go straight to RUN.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `req_i`  in  NumReq  per-requester request; held until granted.
- `write_i`  in  NumReq  per-requester write enable.
- `addr_i`  in  NumReq*Aw  per-requester address, packed.
- `wdata_i`  in  NumReq*Width  per-requester write data, packed.
- `wmask_i`  in  NumReq*Width  per-requester write mask, packed.
- `gnt_o`  out  NumReq  one-hot grant; combinational, same cycle as the request.
- `rvalid_o`  out  NumReq  one-hot read-data valid; registered.
- `rdata_o`  out  Width  read data, shared by all requesters; equals `ram_rdata_i`.
- `init_req_i`  in  1  single-cycle pulse that requests a re-clear.
- `init_done_o`  out  1  high while in RUN.
- `ram_req_o`, `ram_write_o`  out  1 each  RAM port request and write enable.
- `ram_addr_o`  out  Aw  RAM port address.
- `ram_wdata_o`, `ram_wmask_o`  out  Width each  RAM port write data and mask.
- `ram_rdata_i`  in  Width  RAM read data, valid one cycle after a read request.

## Operation
- FSM states: RST, INIT, RUN. Asynchronous reset forces RST.
- RST: no RAM access. On the first clock edge after reset release, go to INIT if `InitOnReset` is set, else to RUN.
- INIT:
  - Each cycle issue a write with `ram_addr_o` = sweep counter, `ram_wdata_o` = 0, `ram_wmask_o` = all ones.
  - Counter starts at 0 and increments by 1 per cycle.
  - After the write to address Depth-1, go to RUN and clear the counter. The sweep takes exactly Depth cycles.
  - `gnt_o` is 0 for the whole state. `init_req_i` is ignored.
- RUN, arbitration:
  - Round-robin pointer `ptr` resets to 0.
  - The winner is the first asserted `req_i[k]` searching k = ptr, ptr+1, ... modulo NumReq.
  - `gnt_o[winner]` = 1; the winner's `write`/`addr`/`wdata`/`wmask` drive the RAM port, and `ram_req_o` = 1.
  - On a grant, `ptr` <= winner+1 modulo NumReq. With no request, `ptr` holds and `ram_req_o` = 0.
- RUN, re-init:
  - `init_req_i` high blocks all grants that cycle; go to INIT on the next edge.
- Reads:
  - A read granted in cycle t sets `rvalid_o[winner]` in cycle t+1, with `rdata_o` = `ram_rdata_i`.
  - Writes produce no `rvalid_o`.
  - A read granted in the last RUN cycle still produces `rvalid_o` in the first INIT cycle.
- When not in RUN, `ram_*` outputs (except during INIT writes) are driven to 0.

## Timing
- Reset values: `gnt_o` = 0, `rvalid_o` = 0, `init_done_o` = 0, `ram_req_o` = 0, `ram_write_o` = 0, `ram_addr_o` = 0, `ram_wdata_o` = 0, `ram_wmask_o` = 0, `ptr` = 0, sweep counter = 0.
- `init_done_o` is registered state (state == RUN). It rises in the cycle after the last INIT write and falls in the cycle after an accepted `init_req_i`.
- Request-to-grant latency is 0 cycles when uncontended. Worst-case wait with all requesters active is NumReq-1 grants.
- Read latency is 1 cycle from grant to `rvalid_o`. At most one bit of `rvalid_o` is set.
- Reset asserted mid-INIT or mid-RUN:
  - Immediately clear `rvalid_o` and the state.
  - An in-flight read response is dropped.
  - A full sweep restarts after release when `InitOnReset` is set.
- Assertions:
  - `gnt_o` is one-hot or zero.
  - No grant outside RUN.
  - `gnt_o` only to requesters with `req_i` set.
  - `ram_req_o` equals `|gnt_o` in RUN.

## Test plan
- Reset with Depth=128 and `InitOnReset`=1 -> 128 consecutive zero writes to addresses 0..127 with mask all ones; `init_done_o` rises on cycle 129 after release; every subsequent read returns 0.
- Requesters 0 and 1 hold `req_i` continuously in RUN -> grants alternate 0,1,0,1 starting with 0; no cycle without a grant.
- Requester 1 writes 0xDEADBEEF with mask 0xFFFF0000 to address 5, then reads address 5 -> `rvalid_o` = 2'b10 exactly one cycle after the read grant, `rdata_o` = 0xDEAD0000.
- In RUN, a read is granted in the same cycle as an `init_req_i` pulse is issued the cycle after -> the read gets its `rvalid_o`; `gnt_o` is 0 for 128 cycles; `init_done_o` is low for those cycles; RAM contents are all zero afterwards.
- Assert `rst_ni` low at sweep address 60 -> outputs return to reset values immediately; after release the sweep restarts at address 0.
- `InitOnReset`=0 -> RUN and `init_done_o` = 1 one cycle after reset release, with no RAM writes issued.
